// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter driving open-drain clock/data
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000,
    parameter int FILTER_CYCLES  = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_busy,
    output logic       o_tx_done,
    output logic       o_tx_ack,
    output logic       o_tx_error,
    output logic       o_rx_inhibit,
    input  logic       i_ps2_clk_in,
    input  logic       i_ps2_data_in,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe
);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PH_W  = (INHIBIT_CYCLES > 16) ? $clog2(INHIBIT_CYCLES) : 5;
    localparam int FLT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

    localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT_CYCLES);
    localparam logic [PH_W-1:0]  INH_LAST = PH_W'(INHIBIT_CYCLES - 1);
    localparam logic [PH_W-1:0]  RTS_LAST = PH_W'(15);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_ACK,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [8:0]        r_shift;
    logic [3:0]        r_bit_cnt;
    logic [PH_W-1:0]   r_ph_cnt;
    logic [WD_W-1:0]   r_wd;
    logic              r_busy;
    logic              r_done;
    logic              r_ack;
    logic              r_error;
    logic              r_clk_oe;
    logic              r_data_oe;

    logic              r_clk_s1;
    logic              r_clk_s2;
    logic              r_data_s1;
    logic              r_data_s2;
    logic              r_clk_filt;
    logic              r_clk_filt_d;
    logic [FLT_W-1:0]  r_flt_cnt;

    logic              w_fe;
    logic [WD_W-1:0]   w_wd_dec;
    logic              w_wd_active;
    logic              w_release_ok;
    logic              w_timeout;

    // Synchronise both pins; the clock additionally needs a stable run before it changes level.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_clk_s1     <= 1'b1;
            r_clk_s2     <= 1'b1;
            r_data_s1    <= 1'b1;
            r_data_s2    <= 1'b1;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
            r_flt_cnt    <= '0;
        end else begin
            r_clk_s1     <= i_ps2_clk_in;
            r_clk_s2     <= r_clk_s1;
            r_data_s1    <= i_ps2_data_in;
            r_data_s2    <= r_data_s1;
            r_clk_filt_d <= r_clk_filt;
            if (r_clk_s2 == r_clk_filt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == FLT_LAST) begin
                r_clk_filt <= r_clk_s2;
                r_flt_cnt  <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + FLT_W'(1);
            end
        end
    end

    assign w_fe         = r_clk_filt_d & ~r_clk_filt;
    assign w_wd_dec     = r_wd - WD_W'(1);
    assign w_wd_active  = (r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_RELEASE);
    assign w_release_ok = (r_state == S_RELEASE) && r_clk_s2 && r_data_s2;
    // A device edge or a completed release always wins over an expiring watchdog.
    assign w_timeout    = w_wd_active && !w_fe && !w_release_ok && (w_wd_dec == '0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_ph_cnt  <= '0;
            r_wd      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack     <= 1'b0;
            r_error   <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_timeout) begin
                r_clk_oe  <= 1'b0;
                r_data_oe <= 1'b0;
                r_error   <= 1'b1;
                r_ack     <= 1'b0;
                r_done    <= 1'b1;
                r_busy    <= 1'b0;
                r_state   <= S_DONE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_tx_start) begin
                            r_shift   <= {~^i_tx_data, i_tx_data};
                            r_bit_cnt <= '0;
                            r_ph_cnt  <= '0;
                            r_ack     <= 1'b0;
                            r_error   <= 1'b0;
                            r_busy    <= 1'b1;
                            r_clk_oe  <= 1'b1;
                            r_data_oe <= 1'b0;
                            r_state   <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        if (r_ph_cnt == INH_LAST) begin
                            r_ph_cnt  <= '0;
                            r_data_oe <= 1'b1;
                            r_state   <= S_RTS;
                        end else begin
                            r_ph_cnt <= r_ph_cnt + PH_W'(1);
                        end
                    end
                    S_RTS: begin
                        if (r_ph_cnt == RTS_LAST) begin
                            r_clk_oe <= 1'b0;
                            r_wd     <= WD_LOAD;
                            r_state  <= S_SEND;
                        end else begin
                            r_ph_cnt <= r_ph_cnt + PH_W'(1);
                        end
                    end
                    S_SEND: begin
                        if (w_fe) begin
                            r_wd      <= WD_LOAD;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd9) begin
                                r_data_oe <= 1'b0;
                                r_state   <= S_ACK;
                            end else begin
                                // Shift register holds {parity, data}; LSB goes out first.
                                r_data_oe <= ~r_shift[0];
                                r_shift   <= {1'b0, r_shift[8:1]};
                            end
                        end else begin
                            r_wd <= w_wd_dec;
                        end
                    end
                    S_ACK: begin
                        if (w_fe) begin
                            r_wd      <= WD_LOAD;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            r_ack     <= ~r_data_s2;
                            r_state   <= S_RELEASE;
                        end else begin
                            r_wd <= w_wd_dec;
                        end
                    end
                    S_RELEASE: begin
                        if (w_release_ok) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else if (w_fe) begin
                            r_wd <= WD_LOAD;
                        end else begin
                            r_wd <= w_wd_dec;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_tx_busy     = r_busy;
    assign o_rx_inhibit  = r_busy;
    assign o_tx_done     = r_done;
    assign o_tx_ack      = r_ack;
    assign o_tx_error    = r_error;
    assign o_ps2_clk_oe  = r_clk_oe;
    assign o_ps2_data_oe = r_data_oe;

endmodule
